// File: rtl/ftdi_cmd_parser.sv
// Byte-stream command parser: decodes write/read frames from the FTDI bridge Rx FIFO
// into single-outstanding 32-bit bus requests and streams read data back LSB first.
module ftdi_cmd_parser (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_accept_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_accept_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic        mem_wr_o,
  output logic        mem_rd_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam logic [7:0] CMD_WR = 8'h10;
  localparam logic [7:0] CMD_RD = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN, ST_ADDR, ST_WDATA, ST_WREQ,
    ST_WACK, ST_RREQ, ST_RACK, ST_RDATA
  } state_e;

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic rx_take;
  logic tx_take;
  logic word_done;

  assign rx_accept_o = !rst_i && (state_q == ST_IDLE || state_q == ST_LEN ||
                                  state_q == ST_ADDR || state_q == ST_WDATA);
  assign tx_valid_o  = (state_q == ST_RDATA);
  assign tx_data_o   = tx_valid_o ? rdata_q[idx_q*8 +: 8] : 8'h00;
  assign mem_wr_o    = (state_q == ST_WREQ);
  assign mem_rd_o    = (state_q == ST_RREQ);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;

  assign rx_take = rx_valid_i && rx_accept_o;
  assign tx_take = tx_valid_o && tx_accept_i;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    count_d   = count_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    word_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (rx_take) begin
          if (rx_data_i == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ST_LEN;
          end else if (rx_data_i == CMD_RD) begin
            is_wr_d = 1'b0;
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        if (rx_take) begin
          count_d = rx_data_i;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_take) begin
          addr_d = {addr_q[23:0], rx_data_i};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (count_q == 8'd0) state_d = ST_IDLE;
            else                 state_d = is_wr_q ? ST_WDATA : ST_RREQ;
          end
        end
      end
      ST_WDATA: begin
        if (rx_take) begin
          wdata_d[idx_q*8 +: 8] = rx_data_i;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_WREQ;
        end
      end
      ST_WREQ: begin
        if (mem_accept_i) begin
          if (mem_ack_i) word_done = 1'b1;
          else           state_d   = ST_WACK;
        end
      end
      ST_WACK: begin
        if (mem_ack_i) word_done = 1'b1;
      end
      ST_RREQ: begin
        if (mem_accept_i) begin
          if (mem_ack_i) begin
            rdata_d = mem_data_i;
            state_d = ST_RDATA;
          end else begin
            state_d = ST_RACK;
          end
        end
      end
      ST_RACK: begin
        if (mem_ack_i) begin
          rdata_d = mem_data_i;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (tx_take) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) word_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared word-completion bookkeeping for both write ack and last read byte.
    if (word_done) begin
      count_d = count_q - 8'd1;
      addr_d  = addr_q + 32'd4;
      if (count_q == 8'd1) state_d = ST_IDLE;
      else                 state_d = is_wr_q ? ST_WDATA : ST_RREQ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      count_q <= 8'd0;
      idx_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
